burst_capture: RTL and testbench
================================

BURST_CAPTURE -- requirements
Module: burst_capture

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, sets the sample ring size to 2^DEPTH_LOG2 words.
REQ-002 Parameter PKT_LEN, default 256, sets data beats per capture packet; legal range 1..2^DEPTH_LOG2-1.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port clear  in  1  synchronous, active-high soft reset.
REQ-006 Ports i_tdata/i_tvalid/i_tready  in/in/out  32/1/1  sample stream.
REQ-007 Ports n_tdata/n_tlast/n_tvalid/n_tready  in/in/in/out  32/1/1/1  notification stream:
- n_tdata = {phase[31:16], offset[15:0]};
- n_tlast = burst-found flag.
REQ-008 Ports o_tdata/o_tlast/o_tvalid/o_tready  out/out/out/in  32/1/1/1  capture packet stream.

Function
REQ-009 Input beat fires when i_tvalid & n_tvalid & in_ok; i_tready = n_tready = that product.
REQ-010 Each fired beat writes i_tdata at wr_ptr and increments wr_ptr modulo 2^DEPTH_LOG2.
REQ-011 A 16-bit fill counter increments on each fired beat and saturates at 2^DEPTH_LOG2.
REQ-012 States: IDLE, HDR, DATA.
REQ-013 IDLE->HDR on a fired beat with n_tlast=1 only when all of the following hold:
- offset < fill counter value including the current beat;
- offset <= 2^DEPTH_LOG2-PKT_LEN.
REQ-014 On that transition:
- rd_ptr = (address written this beat) - offset, modulo ring;
- latch header = n_tdata.
REQ-015 A notification failing REQ-013, or arriving in HDR/DATA, is dropped; the sample is still written.
REQ-016 HDR: o_tvalid=1 with o_tdata=header, starting the cycle after the notification beat; o_tlast=0; advance to DATA on o_tready.
REQ-017 DATA: emit ring[rd_ptr] whenever unread occupancy (wr_ptr-rd_ptr, modulo) > 0; rd_ptr increments per accepted beat.
REQ-018 o_tlast=1 on data beat PKT_LEN; acceptance returns the FSM to IDLE.
REQ-019 in_ok=0 when state≠IDLE and wr_ptr+1 == rd_ptr (modulo); this prevents overwriting unread samples.
REQ-020 o_tvalid/o_tdata/o_tlast are registered and stay stable while o_tvalid=1 & o_tready=0.
REQ-021 Simultaneous last-data accept and notification beat: the notification is dropped, since the FSM is not yet IDLE.
REQ-022 Offset 0 captures starting at the sample accepted with the notification.
REQ-023 Throughput: one data beat per cycle when samples are available and o_tready=1.

Reset
REQ-024 reset_n low asynchronously forces, and clear high synchronously forces:
- state=IDLE;
- wr_ptr=rd_ptr=0, fill=0, header=0;
- o_tvalid=0, o_tlast=0, o_tdata=0.
REQ-025 Ring RAM contents are not reset; fill=0 prevents stale reads.
REQ-026 Reset or clear mid-packet abandons the packet with no tlast; the next output is a fresh header.

Configuration
REQ-027 With macro BURST_CAPTURE_DROP_CNT_EN defined:
- adds output port drop_count[15:0];
- increments once per dropped notification (REQ-015);
- saturates at 0xFFFF;
- reset/clear to 0.
REQ-028 Without BURST_CAPTURE_DROP_CNT_EN: the port and counter are absent and drops are silent; all other behaviour is identical.

Verification
REQ-029 Basic capture:
- stimulus: DEPTH_LOG2=10, PKT_LEN=4; samples 0,1,2,...; notification n_tlast=1 with n_tdata=0x12340003 on sample 10;
- response: header 0x12340003, then data 7,8,9,10, tlast on 10.
REQ-030 Future samples: PKT_LEN=8, offset 2 on sample 20 -> data 18..25 emitted; data stalls (o_tvalid=0) until samples 21..25 arrive.
REQ-031 Illegal offset:
- offset 0x0400 -> no packet, drop_count=1 (macro on);
- offset 5 when fill=3 -> no packet, drop_count=2.
REQ-032 Busy drop: a second notification during DATA -> ignored, drop_count increments, the current packet completes intact.
REQ-033 Backpressure and ring full:
- setup: o_tready=0 in DATA with DEPTH_LOG2=4;
- i_tready falls after 15 unread samples;
- it rises one cycle after o_tready=1 and the first accepted beat;
- no data corrupted.
REQ-034 Reset mid-packet: reset_n pulsed low during data beat 2 -> o_tvalid=0 immediately; the next notification yields a fresh header.

Source files
------------

// File: rtl/burst_capture_if.sv
// Stream bundle for burst_capture: sample input (i_*), notification input (n_*)
// and capture packet output (o_*). The slave modport is the capture block's
// view; the master modport is the view of whatever feeds and drains it.
interface burst_capture_if;
    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;

    logic [31:0] n_tdata;
    logic        n_tlast;
    logic        n_tvalid;
    logic        n_tready;

    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    modport slave (
        input  i_tdata, i_tvalid,
        output i_tready,
        input  n_tdata, n_tlast, n_tvalid,
        output n_tready,
        output o_tdata, o_tlast, o_tvalid,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tvalid,
        input  i_tready,
        output n_tdata, n_tlast, n_tvalid,
        input  n_tready,
        input  o_tdata, o_tlast, o_tvalid,
        output o_tready
    );
endinterface

// File: rtl/burst_capture.sv
// burst_capture: writes every sample into a ring and, when a burst-found
// notification arrives with a usable offset, emits a packet of one header
// beat (the notification word) followed by PKT_LEN samples starting `offset`
// samples before the notifying sample.
// Optional macro BURST_CAPTURE_DROP_CNT_EN adds a saturating drop_count output
// counting notifications that were discarded.
//
// state | meaning
// IDLE  | waiting for a legal burst-found notification
// HDR   | header beat presented on the output
// DATA  | streaming ring samples until the last beat is accepted
module burst_capture #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PKT_LEN    = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
`ifdef BURST_CAPTURE_DROP_CNT_EN
    output logic [15:0] drop_count,
`endif
    burst_capture_if.slave bus
);
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [15:0] FILL_MAX   = 16'(DEPTH);
    localparam logic [15:0] OFFSET_MAX = 16'(DEPTH - PKT_LEN);
    localparam logic [15:0] PKT_LEN_W  = 16'(PKT_LEN);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t      state;
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    logic [15:0] fill;
    logic [15:0] beat_cnt;
    logic [31:0] ring [DEPTH];

    // o_tdata doubles as the header latch while in HDR
    logic [31:0] o_tdata_q;
    logic        o_tlast_q;
    logic        o_tvalid_q;

    logic        in_ok;
    logic        fire;
    logic [15:0] offset;
    logic [15:0] fill_inc;
    logic        legal;
    logic        capture;
    logic        take;
    ptr_t        rd_ptr_adv;
    logic        avail;
    logic        last_load;

    // Stall the input only when one more write would overrun an unread sample
    assign in_ok    = (state == IDLE) || ((wr_ptr + PTR_ONE) != rd_ptr);
    assign fire     = bus.i_tvalid & bus.n_tvalid & in_ok;
    assign offset   = bus.n_tdata[15:0];
    assign fill_inc = (fill == FILL_MAX) ? fill : fill + 16'd1;
    assign legal    = (offset < fill_inc) && (offset <= OFFSET_MAX);
    assign capture  = fire & bus.n_tlast & (state == IDLE) & legal;
    assign take     = o_tvalid_q & bus.o_tready;

    // rd_ptr names the beat currently presented (or next to present); the
    // output register is refilled from the address after any accept this cycle
    assign rd_ptr_adv = ((state == DATA) && take) ? rd_ptr + PTR_ONE : rd_ptr;
    assign avail      = (wr_ptr != rd_ptr_adv);
    assign last_load  = ((beat_cnt + 16'd1) == PKT_LEN_W);

    assign bus.i_tready = fire;
    assign bus.n_tready = fire;
    assign bus.o_tdata  = o_tdata_q;
    assign bus.o_tlast  = o_tlast_q;
    assign bus.o_tvalid = o_tvalid_q;

    // Sample ring storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (fire) ring[wr_ptr] <= bus.i_tdata;
    end

    // Pointers, fill level and the capture FSM with its registered output beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            beat_cnt   <= '0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            beat_cnt   <= '0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                fill   <= fill_inc;
            end
            case (state)
                IDLE: begin
                    if (capture) begin
                        state      <= HDR;
                        rd_ptr     <= wr_ptr - ptr_t'(offset);
                        beat_cnt   <= '0;
                        o_tdata_q  <= bus.n_tdata;
                        o_tlast_q  <= 1'b0;
                        o_tvalid_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (take) begin
                        state <= DATA;
                        if (avail) begin
                            o_tdata_q  <= ring[rd_ptr_adv];
                            o_tlast_q  <= last_load;
                            o_tvalid_q <= 1'b1;
                            beat_cnt   <= beat_cnt + 16'd1;
                        end else begin
                            o_tvalid_q <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    rd_ptr <= rd_ptr_adv;
                    if (take && o_tlast_q) begin
                        state      <= IDLE;
                        o_tvalid_q <= 1'b0;
                        o_tlast_q  <= 1'b0;
                    end else if (!o_tvalid_q || take) begin
                        if (avail) begin
                            o_tdata_q  <= ring[rd_ptr_adv];
                            o_tlast_q  <= last_load;
                            o_tvalid_q <= 1'b1;
                            beat_cnt   <= beat_cnt + 16'd1;
                        end else begin
                            o_tvalid_q <= 1'b0;
                            o_tlast_q  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BURST_CAPTURE_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt;

    // Any fired notification that did not start a capture is a drop
    assign drop       = fire & bus.n_tlast & ~capture;
    assign drop_count = drop_cnt;

    // Saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_cnt <= '0;
        else if (clear)
            drop_cnt <= '0;
        else if (drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_burst_capture.sv
// Directed bench for burst_capture. Two instances share one set of stimulus
// signals: dut_a (DEPTH_LOG2=10, PKT_LEN=4) and dut_b (DEPTH_LOG2=4, PKT_LEN=8);
// `sel` routes the handshakes to one of them.
module tb_burst_capture;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] i_tdata = '0;
    logic [31:0] n_tdata = '0;
    logic        i_tvalid = 1'b0;
    logic        n_tvalid = 1'b0;
    logic        n_tlast = 1'b0;
    logic        o_tready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [32:0] out_q[$];

    burst_capture_if bus_a ();
    burst_capture_if bus_b ();

    assign bus_a.i_tdata  = i_tdata;
    assign bus_a.n_tdata  = n_tdata;
    assign bus_a.n_tlast  = n_tlast;
    assign bus_a.i_tvalid = i_tvalid & ~sel;
    assign bus_a.n_tvalid = n_tvalid & ~sel;
    assign bus_a.o_tready = o_tready & ~sel;
    assign bus_b.i_tdata  = i_tdata;
    assign bus_b.n_tdata  = n_tdata;
    assign bus_b.n_tlast  = n_tlast;
    assign bus_b.i_tvalid = i_tvalid & sel;
    assign bus_b.n_tvalid = n_tvalid & sel;
    assign bus_b.o_tready = o_tready & sel;

    wire        i_tready = sel ? bus_b.i_tready : bus_a.i_tready;
    wire        n_tready = sel ? bus_b.n_tready : bus_a.n_tready;
    wire [31:0] o_tdata  = sel ? bus_b.o_tdata  : bus_a.o_tdata;
    wire        o_tlast  = sel ? bus_b.o_tlast  : bus_a.o_tlast;
    wire        o_tvalid = sel ? bus_b.o_tvalid : bus_a.o_tvalid;

`ifdef BURST_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_a, drop_b;
    wire  [15:0] drop_count = sel ? drop_b : drop_a;
`endif

    burst_capture #(.DEPTH_LOG2(10), .PKT_LEN(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear),
`ifdef BURST_CAPTURE_DROP_CNT_EN
        .drop_count(drop_a),
`endif
        .bus(bus_a.slave)
    );

    burst_capture #(.DEPTH_LOG2(4), .PKT_LEN(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear),
`ifdef BURST_CAPTURE_DROP_CNT_EN
        .drop_count(drop_b),
`endif
        .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    // Record every output beat that will be accepted at the next rising edge
    always @(negedge clk) begin
        if (o_tvalid && o_tready) out_q.push_back({o_tlast, o_tdata});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        i_tvalid = 1'b0;
        n_tvalid = 1'b0;
        n_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one sample (+ notification word) and return just after it fires
    task automatic push(input logic [31:0] d, input logic last, input logic [31:0] nd);
        bit done = 1'b0;
        i_tdata = d; n_tdata = nd; n_tlast = last;
        i_tvalid = 1'b1; n_tvalid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (i_tready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL push_timeout got no i_tready exp fire for sample %h", d);
        end
    endtask

    task automatic clear_all();
        drive_idle();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        o_tready = 1'b1;
        out_q.delete();
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_tvalid, o_tlast, o_tdata} !== 34'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got v=%b l=%b d=%h exp all zero", s, o_tvalid, o_tlast, o_tdata);
            end
        end
        sel = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        i_tvalid = 1'b1; n_tvalid = 1'b0;
        #1;
        checks++;
        if (i_tready !== 1'b0) begin
            errors++; $display("FAIL ready_needs_both got %b exp 0", i_tready);
        end
        n_tvalid = 1'b1;
        #1;
        checks++;
        if ({i_tready, n_tready} !== 2'b11) begin
            errors++; $display("FAIL ready_idle got %b%b exp 11", i_tready, n_tready);
        end
`ifdef BURST_CAPTURE_DROP_CNT_EN
        checks++;
        if (drop_count !== 16'h0) begin
            errors++; $display("FAIL reset_drop got %h exp 0000", drop_count);
        end
`endif
        drive_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [32:0] exp_q[$];
        sel = 1'b0;
        clear_all();
        for (int i = 0; i < 10; i++) push(32'(i), 1'b0, 32'h0);
        push(32'd10, 1'b1, 32'h12340003);
        checks++;
        if ({o_tvalid, o_tlast, o_tdata} !== {2'b10, 32'h12340003}) begin
            errors++;
            $display("FAIL basic_hdr_timing got v=%b l=%b d=%h exp v=1 l=0 d=12340003", o_tvalid, o_tlast, o_tdata);
        end
        idle(10);
        exp_q.push_back({1'b0, 32'h12340003});
        for (int i = 7; i <= 10; i++) exp_q.push_back({(i == 10), 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL basic_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_future();
        logic [32:0] exp_q[$];
        sel = 1'b1;
        clear_all();
        for (int i = 0; i < 20; i++) push(32'(i), 1'b0, 32'h0);
        push(32'd20, 1'b1, 32'hABCD0002);
        idle(10);
        checks++;
        if (o_tvalid !== 1'b0 || out_q.size() != 4) begin
            errors++;
            $display("FAIL future_stall got v=%b beats=%0d exp v=0 beats=4", o_tvalid, out_q.size());
        end
        for (int i = 21; i <= 25; i++) push(32'(i), 1'b0, 32'h0);
        idle(10);
        exp_q.push_back({1'b0, 32'hABCD0002});
        for (int i = 18; i <= 25; i++) exp_q.push_back({(i == 25), 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL future_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL future_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [32:0] exp_q[$];
        sel = 1'b0;
        clear_all();
        push(32'h100, 1'b1, 32'h00000400);
`ifdef BURST_CAPTURE_DROP_CNT_EN
        checks++;
        if (drop_count !== 16'd1) begin
            errors++; $display("FAIL illegal_drop1 got %0d exp 1", drop_count);
        end
`endif
        push(32'h101, 1'b0, 32'h0);
        push(32'h102, 1'b1, 32'h00000005);
        idle(5);
        checks++;
        if (o_tvalid !== 1'b0 || out_q.size() != 0) begin
            errors++; $display("FAIL illegal_nopkt got v=%b beats=%0d exp v=0 beats=0", o_tvalid, out_q.size());
        end
`ifdef BURST_CAPTURE_DROP_CNT_EN
        checks++;
        if (drop_count !== 16'd2) begin
            errors++; $display("FAIL illegal_drop2 got %0d exp 2", drop_count);
        end
`endif
        // offset one below the fill level (including this beat) is the oldest legal start
        push(32'h103, 1'b1, 32'h00000003);
        idle(10);
        exp_q.push_back({1'b0, 32'h00000003});
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'h100 + 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL filledge_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL filledge_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_offset_limit();
        logic [32:0] exp_q[$];
        sel = 1'b1;
        clear_all();
        for (int i = 0; i < 9; i++) push(32'h200 + 32'(i), 1'b0, 32'h0);
        push(32'h209, 1'b1, 32'h00000009);
        push(32'h20A, 1'b1, 32'h00000008);
        idle(14);
`ifdef BURST_CAPTURE_DROP_CNT_EN
        checks++;
        if (drop_count !== 16'd1) begin
            errors++; $display("FAIL limit_drop got %0d exp 1", drop_count);
        end
`endif
        exp_q.push_back({1'b0, 32'h00000008});
        for (int i = 2; i <= 9; i++) exp_q.push_back({(i == 9), 32'h200 + 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL limit_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL limit_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_busy();
        logic [32:0] exp_q[$];
        sel = 1'b0;
        clear_all();
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i), 1'b0, 32'h0);
        push(32'h304, 1'b1, 32'h55550001);
        push(32'h305, 1'b1, 32'h0);   // arrives in HDR
        push(32'h306, 1'b1, 32'h0);   // arrives in DATA
        push(32'h307, 1'b0, 32'h0);
        push(32'h308, 1'b0, 32'h0);
        push(32'h309, 1'b1, 32'h0);   // same edge as last-beat accept
        idle(8);
`ifdef BURST_CAPTURE_DROP_CNT_EN
        checks++;
        if (drop_count !== 16'd3) begin
            errors++; $display("FAIL busy_drop got %0d exp 3", drop_count);
        end
`endif
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++; $display("FAIL busy_no_new_pkt got v=%b exp 0", o_tvalid);
        end
        exp_q.push_back({1'b0, 32'h55550001});
        for (int i = 3; i <= 6; i++) exp_q.push_back({(i == 6), 32'h300 + 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL busy_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL busy_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_q[$];
        sel = 1'b1;
        clear_all();
        push(32'h400, 1'b1, 32'h77770000);
        push(32'h401, 1'b0, 32'h0);
        o_tready = 1'b0;
        for (int i = 2; i < 15; i++) push(32'h400 + 32'(i), 1'b0, 32'h0);
        i_tdata = 32'h40F; n_tdata = 32'h0; n_tlast = 1'b0;
        i_tvalid = 1'b1; n_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (i_tready !== 1'b0) begin
                errors++; $display("FAIL full_block cycle%0d got %b exp 0", c, i_tready);
            end
            checks++;
            if ({o_tvalid, o_tdata} !== {1'b1, 32'h400}) begin
                errors++; $display("FAIL hold_stable cycle%0d got v=%b d=%h exp v=1 d=00000400", c, o_tvalid, o_tdata);
            end
            @(posedge clk);
            #1;
        end
        o_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b0) begin
            errors++; $display("FAIL full_before_accept got %b exp 0", i_tready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1) begin
            errors++; $display("FAIL full_release got %b exp 1", i_tready);
        end
        @(posedge clk);
        #1;
        idle(15);
        exp_q.push_back({1'b0, 32'h77770000});
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'h400 + 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp_q[$];
        bit found = 1'b0;
        sel = 1'b0;
        clear_all();
        for (int i = 0; i < 5; i++) push(32'h500 + 32'(i), 1'b0, 32'h0);
        push(32'h505, 1'b1, 32'h88880002);
        drive_idle();
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (o_tvalid && o_tdata == 32'h504) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midrst_beat2 got no beat 00000504 exp beat within 20 cycles");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({o_tvalid, o_tlast} !== 2'b00) begin
            errors++; $display("FAIL midrst_async got v=%b l=%b exp 00", o_tvalid, o_tlast);
        end
        checks++;
        if (out_q.size() != 2 || out_q[0] !== {1'b0, 32'h88880002} || out_q[1] !== {1'b0, 32'h503}) begin
            errors++; $display("FAIL midrst_partial got %0d beats exp hdr + 00000503 without tlast", out_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_q.delete();
        @(posedge clk);
        #1;
        push(32'h600, 1'b1, 32'h99990000);
        for (int i = 1; i < 4; i++) push(32'h600 + 32'(i), 1'b0, 32'h0);
        idle(10);
        exp_q.push_back({1'b0, 32'h99990000});
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'h600 + 32'(i)});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL midrst_beat%0d got %h exp %h", k, (k < out_q.size()) ? out_q[k] : 33'h0, exp_q[k]);
            end
        end
    endtask

    initial begin
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_future();
        test_illegal();
        test_offset_limit();
        test_busy();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
